// File: rtl/fp_consts_pkg.sv
// ---------------------------------------------------------------------------
// fp_consts_pkg
// Shared float32 constants and encodings for the sine/cosine/arccosine family.
//   - fp32_t      : packed view of an IEEE-754 single-precision word
//   - fp_op_e     : add/subtract select for cong_tru
//   - C0..C6      : asin Maclaurin coefficients (float32, round-to-nearest)
//   - PI_2/PI     : pi/2 and pi
//   - QNAN/ONE    : canonical quiet NaN and 1.0
//   - ST_*        : acos_seq FSM state encodings
// ---------------------------------------------------------------------------
package fp_consts_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef enum logic {
    FP_ADD = 1'b0,
    FP_SUB = 1'b1
  } fp_op_e;

  // asin(x) = x * sum_k c_k * x^(2k); c_k = (2k)! / (4^k (k!)^2 (2k+1))
  localparam logic [31:0] C0 = 32'h3F80_0000;  // 1
  localparam logic [31:0] C1 = 32'h3E2A_AAAB;  // 1/6
  localparam logic [31:0] C2 = 32'h3D99_999A;  // 3/40
  localparam logic [31:0] C3 = 32'h3D36_DB6E;  // 15/336
  localparam logic [31:0] C4 = 32'h3CF8_E38E;  // 105/3456
  localparam logic [31:0] C5 = 32'h3CB7_45D1;  // 945/42240
  localparam logic [31:0] C6 = 32'h3C8E_2762;  // 10395/599040

  localparam logic [31:0] PI_2 = 32'h3FC9_0FDB;
  localparam logic [31:0] PI   = 32'h4049_0FDB;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] ONE  = 32'h3F80_0000;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SQ   = 3'd1;
  localparam logic [2:0] ST_MUL  = 3'd2;
  localparam logic [2:0] ST_ADD  = 3'd3;
  localparam logic [2:0] ST_MULX = 3'd4;
  localparam logic [2:0] ST_SUB  = 3'd5;
  localparam logic [2:0] ST_BYP  = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

endpackage

// File: rtl/acos_coef_rom.sv
// ---------------------------------------------------------------------------
// acos_coef_rom
// Combinational coefficient table for the asin Horner evaluation.
//   k_i    [2:0]  : coefficient index (0..6; 7 returns +0)
//   coef_o [31:0] : c_k as float32
// ---------------------------------------------------------------------------
module acos_coef_rom
  import fp_consts_pkg::*;
(
  input  logic [2:0]  k_i,
  output logic [31:0] coef_o
);

  always_comb begin
    coef_o = 32'h0000_0000;
    case (k_i)
      3'd0:    coef_o = C0;
      3'd1:    coef_o = C1;
      3'd2:    coef_o = C2;
      3'd3:    coef_o = C3;
      3'd4:    coef_o = C4;
      3'd5:    coef_o = C5;
      3'd6:    coef_o = C6;
      default: coef_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/cong_tru.sv
// ---------------------------------------------------------------------------
// cong_tru
// Combinational float32 adder/subtractor, round-to-nearest-even.
// Subnormal operands are treated as zero and underflowing results flush to
// signed zero.
//   a_i, b_i [31:0] : operands
//   op_i            : FP_ADD -> a+b, FP_SUB -> a-b
//   y_o      [31:0] : result
// ---------------------------------------------------------------------------
module cong_tru
  import fp_consts_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  fp_op_e      op_i,
  output logic [31:0] y_o
);

  fp32_t              a, b, lrg, sml;
  logic               swap, eff_sub, sticky, guard, rs_sticky;
  logic               a_nan, b_nan, a_inf, b_inf;
  logic [7:0]         d;
  logic [26:0]        ml, ms_ext, ms_sh, norm;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic [23:0]        rnd;
  logic signed [9:0]  e_n, e_f;

  always_comb begin
    a      = a_i;
    b      = b_i;
    b.sign = b_i[31] ^ (op_i == FP_SUB);

    a_nan = (a.exp == 8'hFF) && (a.man != 23'd0);
    b_nan = (b.exp == 8'hFF) && (b.man != 23'd0);
    a_inf = (a.exp == 8'hFF) && (a.man == 23'd0);
    b_inf = (b.exp == 8'hFF) && (b.man == 23'd0);

    // Order by magnitude so the aligned difference is never negative.
    swap = {b.exp, b.man} > {a.exp, a.man};
    lrg  = swap ? b : a;
    sml  = swap ? a : b;

    // Mantissas carry three extra bits: guard, round, sticky.
    ml     = (lrg.exp != 8'h00) ? {1'b1, lrg.man, 3'b000} : 27'd0;
    ms_ext = (sml.exp != 8'h00) ? {1'b1, sml.man, 3'b000} : 27'd0;
    d      = lrg.exp - sml.exp;

    if (d >= 8'd27) begin
      ms_sh  = 27'd0;
      sticky = |ms_ext;
    end else begin
      ms_sh  = ms_ext >> d;
      sticky = |(ms_ext & ~({27{1'b1}} << d));
    end
    ms_sh = ms_sh | {26'd0, sticky};

    eff_sub = lrg.sign ^ sml.sign;
    sum = eff_sub ? ({1'b0, ml} - {1'b0, ms_sh}) : ({1'b0, ml} + {1'b0, ms_sh});

    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    if (sum[27]) begin
      norm = sum[27:1] | {26'd0, sum[0]};
      e_n  = {2'b00, lrg.exp} + 10'd1;
    end else begin
      norm = sum[26:0] << lz;
      e_n  = {2'b00, lrg.exp} - {5'd0, lz};
    end

    guard     = norm[2];
    rs_sticky = |norm[1:0];
    rnd       = {1'b0, norm[25:3]} + 24'(guard & (rs_sticky | norm[3]));
    e_f       = e_n + {9'd0, rnd[23]};

    if (a_nan || b_nan) begin
      y_o = QNAN;
    end else if (a_inf && b_inf) begin
      y_o = (a.sign != b.sign) ? QNAN : {a.sign, 8'hFF, 23'd0};
    end else if (a_inf) begin
      y_o = {a.sign, 8'hFF, 23'd0};
    end else if (b_inf) begin
      y_o = {b.sign, 8'hFF, 23'd0};
    end else if (!norm[26]) begin
      // Exact zero: -0 only when both addends are -0.
      y_o = {a.sign & b.sign, 31'd0};
    end else if (e_f >= 10'sd255) begin
      y_o = {lrg.sign, 8'hFF, 23'd0};
    end else if (e_f <= 10'sd0) begin
      y_o = {lrg.sign, 31'd0};
    end else begin
      y_o = {lrg.sign, e_f[7:0], rnd[22:0]};
    end
  end

endmodule

// File: rtl/nhan.sv
// ---------------------------------------------------------------------------
// nhan
// Combinational float32 multiplier, round-to-nearest-even.
// Subnormal operands are treated as zero and underflowing results flush to
// signed zero.
//   a_i, b_i [31:0] : operands
//   y_o      [31:0] : a_i * b_i
// ---------------------------------------------------------------------------
module nhan
  import fp_consts_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  fp32_t              a, b;
  logic               sign;
  logic               a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic [47:0]        prod;
  logic [22:0]        frac;
  logic               guard, sticky;
  logic [23:0]        rnd;
  logic signed [10:0] e_sum, e_fin;

  always_comb begin
    a      = a_i;
    b      = b_i;
    sign   = a.sign ^ b.sign;
    a_zero = (a.exp == 8'h00);
    b_zero = (b.exp == 8'h00);
    a_nan  = (a.exp == 8'hFF) && (a.man != 23'd0);
    b_nan  = (b.exp == 8'hFF) && (b.man != 23'd0);
    a_inf  = (a.exp == 8'hFF) && (a.man == 23'd0);
    b_inf  = (b.exp == 8'hFF) && (b.man == 23'd0);

    prod = {1'b1, a.man} * {1'b1, b.man};

    // Product of two [1,2) mantissas lies in [1,4); prod[47] picks the binade.
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    e_sum = {3'b000, a.exp} + {3'b000, b.exp} + {10'd0, prod[47]} - 11'd127;

    // rnd[23] is the carry out of rounding 1.111..1 up to 2.0.
    rnd   = {1'b0, frac} + 24'(guard & (sticky | frac[0]));
    e_fin = e_sum + {10'd0, rnd[23]};

    if (a_nan || b_nan) begin
      y_o = QNAN;
    end else if (a_inf || b_inf) begin
      y_o = (a_zero || b_zero) ? QNAN : {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      y_o = {sign, 31'd0};
    end else if (e_fin >= 11'sd255) begin
      y_o = {sign, 8'hFF, 23'd0};
    end else if (e_fin <= 11'sd0) begin
      y_o = {sign, 31'd0};
    end else begin
      y_o = {sign, e_fin[7:0], rnd[22:0]};
    end
  end

endmodule

// File: rtl/acos_seq.sv
// ---------------------------------------------------------------------------
// acos_seq
// Sequential float32 arccosine: acos(x) = pi/2 - asin(x), asin as a 7-term
// Horner series sharing one multiplier and one adder.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   in_valid   : x present on `in`
//   in_ready   : accepting (IDLE only)
//   in  [31:0] : x, float32
//   out_valid  : result held until out_ready
//   out_ready  : consumer accepts result
//   out [31:0] : acos(x), float32
//   invalid    : x was NaN or |x| > 1 (out = QNAN)
// ---------------------------------------------------------------------------
module acos_seq
  import fp_consts_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        invalid
);

  logic [2:0]  state_q, state_d;
  logic [31:0] xr_q, xr_d;
  logic [31:0] x2_q, x2_d;
  logic [31:0] acc_q, acc_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] out_q, out_d;
  logic        invalid_q, invalid_d;

  logic [31:0] mul_a, mul_b, mul_y;
  logic [31:0] add_a, add_b, add_y;
  fp_op_e      add_op;
  logic [31:0] coef;

  acos_coef_rom u_rom (
    .k_i    (k_q),
    .coef_o (coef)
  );

  nhan u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .y_o (mul_y)
  );

  cong_tru u_add (
    .a_i  (add_a),
    .b_i  (add_b),
    .op_i (add_op),
    .y_o  (add_y)
  );

  // Shared operator operand selection.
  always_comb begin
    mul_a  = acc_q;
    mul_b  = x2_q;
    add_a  = acc_q;
    add_b  = coef;
    add_op = FP_ADD;
    case (state_q)
      ST_SQ: begin
        mul_a = xr_q;
        mul_b = xr_q;
      end
      ST_MULX: begin
        mul_b = xr_q;
      end
      ST_SUB: begin
        add_a  = PI_2;
        add_b  = acc_q;
        add_op = FP_SUB;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    xr_d      = xr_q;
    x2_d      = x2_q;
    acc_d     = acc_q;
    k_d       = k_q;
    out_d     = out_q;
    invalid_d = invalid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          xr_d = in;
          // Magnitude compare on the raw bits also catches Inf and NaN.
          if (in[30:0] > ONE[30:0]) begin
            out_d     = QNAN;
            invalid_d = 1'b1;
            state_d   = ST_BYP;
          end else if (in == ONE) begin
            out_d     = 32'h0000_0000;
            invalid_d = 1'b0;
            state_d   = ST_BYP;
          end else if (in == {1'b1, ONE[30:0]}) begin
            out_d     = PI;
            invalid_d = 1'b0;
            state_d   = ST_BYP;
          end else begin
            state_d = ST_SQ;
          end
        end
      end
      ST_SQ: begin
        x2_d    = mul_y;
        acc_d   = C6;
        k_d     = 3'd5;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        acc_d   = mul_y;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        acc_d = add_y;
        if (k_q == 3'd0) begin
          state_d = ST_MULX;
        end else begin
          k_d     = k_q - 3'd1;
          state_d = ST_MUL;
        end
      end
      ST_MULX: begin
        acc_d   = mul_y;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        out_d     = add_y;
        invalid_d = 1'b0;
        state_d   = ST_DONE;
      end
      ST_BYP: begin
        // Result was registered at accept; this stage only aligns timing.
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      xr_q      <= 32'd0;
      x2_q      <= 32'd0;
      acc_q     <= 32'd0;
      k_q       <= 3'd0;
      out_q     <= 32'd0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      xr_q      <= xr_d;
      x2_q      <= x2_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      out_q     <= out_d;
      invalid_q <= invalid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_acos_seq.sv
module tb_acos_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        invalid;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] K_PI_2 = 32'h3FC9_0FDB;
  localparam logic [31:0] K_PI   = 32'h4049_0FDB;
  localparam logic [31:0] K_QNAN = 32'h7FC0_0000;

  acos_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_data),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ulp_dist(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Distance reported as 0 when within tolerance, else the raw distance.
  function automatic logic [31:0] ulp_excess(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] dd;
    dd = ulp_dist(a, b);
    return (dd <= 32'd8) ? 32'd0 : dd;
  endfunction

  // One transaction with out_ready held high. Called away from a clock edge.
  task automatic run_x(input logic [31:0] x, output logic [31:0] res,
                       output logic res_inv, output int lat);
    in_valid  = 1'b1;
    in_data   = x;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("valid_seen", 32'(out_valid), 32'd1);
    res     = out_data;
    res_inv = invalid;
    $display("txn x=%h out=%h invalid=%0d latency=%0d", x, res, res_inv, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        ri;
    int          lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_in_ready",  32'(in_ready),  32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out",       out_data,       32'd0);
    check_val("rst_invalid",   32'(invalid),   32'd0);

    run_x(32'h0000_0000, r, ri, lat);
    check_val("p0_out", r, K_PI_2);
    check_val("p0_inv", 32'(ri), 32'd0);
    check_val("p0_lat", 32'(lat), 32'd15);
    check_val("p0_idle", 32'(in_ready), 32'd1);

    run_x(32'h8000_0000, r, ri, lat);
    check_val("n0_out", r, K_PI_2);
    check_val("n0_lat", 32'(lat), 32'd15);

    // pi/2 - 2^-24 is a tie; round-to-even gives ...DA, and the + case ...DC.
    run_x(32'h3380_0000, r, ri, lat);
    check_val("ptiny_out", r, 32'h3FC9_0FDA);
    run_x(32'hB380_0000, r, ri, lat);
    check_val("ntiny_out", r, 32'h3FC9_0FDC);

    run_x(32'h3F00_0000, r, ri, lat);
    check_val("p05_ulp_excess", ulp_excess(r, 32'h3F86_0A92), 32'd0);
    check_val("p05_inv", 32'(ri), 32'd0);
    run_x(32'hBF00_0000, r, ri, lat);
    check_val("n05_ulp_excess", ulp_excess(r, 32'h4006_0A92), 32'd0);
    check_val("n05_inv", 32'(ri), 32'd0);

    run_x(32'h3F80_0000, r, ri, lat);
    check_val("p1_out", r, 32'h0000_0000);
    check_val("p1_inv", 32'(ri), 32'd0);
    check_val("p1_lat", 32'(lat), 32'd1);
    run_x(32'hBF80_0000, r, ri, lat);
    check_val("n1_out", r, K_PI);
    check_val("n1_lat", 32'(lat), 32'd1);

    run_x(32'h4000_0000, r, ri, lat);
    check_val("two_out", r, K_QNAN);
    check_val("two_inv", 32'(ri), 32'd1);
    check_val("two_lat", 32'(lat), 32'd1);
    run_x(32'h7FC0_0000, r, ri, lat);
    check_val("nan_out", r, K_QNAN);
    check_val("nan_inv", 32'(ri), 32'd1);
    check_val("nan_lat", 32'(lat), 32'd1);
    run_x(32'h7F80_0000, r, ri, lat);
    check_val("inf_out", r, K_QNAN);
    check_val("inf_inv", 32'(ri), 32'd1);

    // Reset on the 7th edge after accept discards the in-flight x=0.5.
    in_valid  = 1'b1;
    in_data   = 32'h3F00_0000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn midop_reset in_ready=%0d out_valid=%0d out=%h invalid=%0d",
             in_ready, out_valid, out_data, invalid);
    check_val("mrst_in_ready",  32'(in_ready),  32'd1);
    check_val("mrst_out_valid", 32'(out_valid), 32'd0);
    check_val("mrst_out",       out_data,       32'd0);
    check_val("mrst_invalid",   32'(invalid),   32'd0);
    run_x(32'h0000_0000, r, ri, lat);
    check_val("mrst_p0_out", r, K_PI_2);
    check_val("mrst_p0_lat", 32'(lat), 32'd15);

    // Backpressure: result held, busy-time in_valid ignored.
    in_valid  = 1'b1;
    in_data   = 32'hBF80_0000;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("hold_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 32'h0000_0000;
      @(posedge clk); #1;
      check_val("hold_out",      out_data,        K_PI);
      check_val("hold_valid",    32'(out_valid),  32'd1);
      check_val("hold_in_ready", 32'(in_ready),   32'd0);
    end
    // in_valid high on the release edge must not be taken.
    in_valid  = 1'b1;
    in_data   = 32'h4000_0000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("rel_in_ready",  32'(in_ready),  32'd1);
    check_val("rel_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("rel_no_capture", 32'(in_ready), 32'd1);
    $display("txn hold x=bf800000 out=%h held=10 released", K_PI);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
